// File: rtl/iz_loader_pkg.sv
// Shared types and constants for the Izhikevich parameter loader.
// Reset constants are also used by the neuron bench.
package iz_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } state_t;

  localparam int FRAME_DATA_BYTES = 8;
  localparam int SHADOW_BYTES = FRAME_DATA_BYTES - 1;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [15:0] RST_A = 16'h0001;
  localparam logic [15:0] RST_B = 16'h000D;
  localparam logic [15:0] RST_C = 16'hEFC0;
  localparam logic [15:0] RST_D = 16'h0200;

endpackage

// File: rtl/iz_param_loader_if.sv
// Byte-stream input and committed-parameter output bundle.
// master = byte source / parameter consumer, slave = loader.
interface iz_param_loader_if;

  logic [7:0]  data_in;
  logic        data_valid;
  logic [15:0] param_a;
  logic [15:0] param_b;
  logic [15:0] param_c;
  logic [15:0] param_d;
  logic        params_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_error;

  modport master (
    output data_in,
    output data_valid,
    input  param_a,
    input  param_b,
    input  param_c,
    input  param_d,
    input  params_ready,
    input  load_busy,
    input  load_done,
    input  load_error
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output param_a,
    output param_b,
    output param_c,
    output param_d,
    output params_ready,
    output load_busy,
    output load_done,
    output load_error
  );

endinterface

// File: rtl/iz_loader_timeout.sv
// Inter-byte idle timer; expire is asserted on the idle cycle
// at which the count has reached TIMEOUT_CYCLES-1.
module iz_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expire = run && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iz_param_loader.sv
// Byte-serial loader for the Izhikevich neuron parameters a..d.
// Define IZ_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module iz_param_loader
  import iz_loader_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE    = HEADER_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] RST_A          = iz_loader_pkg::RST_A,
  parameter logic [15:0] RST_B          = iz_loader_pkg::RST_B,
  parameter logic [15:0] RST_C          = iz_loader_pkg::RST_C,
  parameter logic [15:0] RST_D          = iz_loader_pkg::RST_D
) (
  input logic              clk,
  input logic              reset_n,
  iz_param_loader_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_DATA_BYTES - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] idx;
  logic [7:0] shadow [SHADOW_BYTES];
  logic [7:0] last_byte;

  logic hdr;
  logic take;
  logic commit;
  logic abort;
  logic expire;
  logic t_clear;
  logic t_run;

  logic [15:0] param_a;
  logic [15:0] param_b;
  logic [15:0] param_c;
  logic [15:0] param_d;
  logic        params_ready;
  logic        load_done;
  logic        load_error;

`ifdef IZ_LOADER_CHECKSUM_EN
  logic [7:0] chk;
  logic [7:0] d_lo;
`endif

  assign take = (state == DATA) && bus.data_valid;

  assign t_clear = (state == IDLE) || bus.data_valid;
  assign t_run   = (state != IDLE) && !bus.data_valid;

  iz_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (t_clear),
    .run    (t_run),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hdr      = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.data_valid && (bus.data_in == HEADER_BYTE)) begin
          hdr      = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bus.data_valid) begin
          if (idx == LAST_IDX) begin
`ifdef IZ_LOADER_CHECKSUM_EN
            state_nx = CHECK;
`else
            commit   = 1'b1;
            state_nx = IDLE;
`endif
          end
        end else if (expire) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      CHECK: begin
`ifdef IZ_LOADER_CHECKSUM_EN
        if (bus.data_valid) begin
          commit   = ((chk ^ bus.data_in) == 8'h00);
          abort    = !commit;
          state_nx = IDLE;
        end else if (expire) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Without the checksum the final data byte is committed straight off the bus.
`ifdef IZ_LOADER_CHECKSUM_EN
  assign last_byte = d_lo;
`else
  assign last_byte = bus.data_in;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      for (int i = 0; i < SHADOW_BYTES; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      if (hdr) begin
        idx <= '0;
      end else if (take) begin
        idx <= idx + 1'b1;
      end
      for (int i = 0; i < SHADOW_BYTES; i++) begin
        if (take && (idx == 3'(i))) begin
          shadow[i] <= bus.data_in;
        end
      end
    end
  end

`ifdef IZ_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk  <= '0;
      d_lo <= '0;
    end else begin
      if (hdr) begin
        chk <= bus.data_in;
      end else if (take) begin
        chk <= chk ^ bus.data_in;
      end
      if (take && (idx == LAST_IDX)) begin
        d_lo <= bus.data_in;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      param_a      <= RST_A;
      param_b      <= RST_B;
      param_c      <= RST_C;
      param_d      <= RST_D;
      params_ready <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      load_done <= commit;
      if (commit) begin
        param_a      <= {shadow[0], shadow[1]};
        param_b      <= {shadow[2], shadow[3]};
        param_c      <= {shadow[4], shadow[5]};
        param_d      <= {shadow[6], last_byte};
        params_ready <= 1'b1;
      end
      if (hdr) begin
        load_error <= 1'b0;
      end else if (abort) begin
        load_error <= 1'b1;
      end
    end
  end

  assign bus.param_a      = param_a;
  assign bus.param_b      = param_b;
  assign bus.param_c      = param_c;
  assign bus.param_d      = param_d;
  assign bus.params_ready = params_ready;
  assign bus.load_busy    = (state != IDLE);
  assign bus.load_done    = load_done;
  assign bus.load_error   = load_error;

endmodule
